queue_push_arbiter: RTL and testbench

//  Shares the single push port of one circular FIFO (queue) among NUM_REQ producers.

---
 rtl/queue_arb_pkg.sv | 10 +
 rtl/rr_priority_pick.sv | 29 ++
 rtl/queue_push_arbiter.sv | 93 +++++++++
 tb/tb_queue_push_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/queue_arb_pkg.sv
// Shared types for the queue push arbiter: FSM state encoding and hold counter width.
package queue_arb_pkg;
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int HOLD_W = 4;
endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first asserted request at or after ptr, wrapping at NUM_REQ.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx,
    output logic               valid
);
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            int cand;
            // Explicit wrap keeps non-power-of-two NUM_REQ in range.
            cand = int'(ptr) + j;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (en && !valid && req[cand]) begin
                valid       = 1'b1;
                idx         = PTR_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/queue_push_arbiter.sv
// Round-robin arbiter sharing one queue push port among NUM_REQ producers; also sequences queue flushes.
module queue_push_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_IN,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_IN,
    output logic [NUM_REQ-1:0]            grant_OUT,
    input  logic                          flushReq_IN,
    input  logic                          qFull_IN,
    output logic                          qPushReq_OUT,
    output logic [DATA_WIDTH-1:0]         qData_OUT,
    output logic                          qFlush_OUT,
    output logic                          busy_OUT,
    output logic [CNT_WIDTH-1:0]          grantCount_OUT
);
    import queue_arb_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t              state, next_state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [CNT_WIDTH-1:0] grant_cnt;
    logic                pick_en, pick_valid;
    logic [PTR_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0]  pick_grant;

    rr_priority_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req   (req_IN),
        .ptr   (rr_ptr),
        .en    (pick_en),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_RUN;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        // Reset gates the grant path so combinational outputs are 0 while reset is high.
        pick_en    = (state == ST_RUN) && !qFull_IN && !flushReq_IN && !reset;
        busy_OUT   = (state != ST_RUN);
        qFlush_OUT = (state == ST_FLUSH);
        case (state)
            ST_RUN:   if (flushReq_IN) next_state = ST_FLUSH;
            ST_FLUSH: next_state = ST_HOLD;
            ST_HOLD: begin
                if (flushReq_IN)        next_state = ST_FLUSH;
                else if (hold_cnt == '0) next_state = ST_RUN;
            end
            default:  next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            grant_cnt <= '0;
        end else begin
            case (state)
                ST_FLUSH: begin
                    hold_cnt  <= HOLD_W'(HOLD_CYCLES - 1);
                    rr_ptr    <= '0;
                    grant_cnt <= '0;
                end
                ST_HOLD: begin
                    if (!flushReq_IN && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
                end
                default: begin
                    if (pick_valid) begin
                        rr_ptr    <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        grant_cnt <= grant_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign grant_OUT      = pick_grant;
    assign qPushReq_OUT   = pick_valid;
    assign qData_OUT      = pick_valid ? data_IN[pick_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign grantCount_OUT = grant_cnt;
endmodule

// File: tb/tb_queue_push_arbiter.sv
// Directed bench for queue_push_arbiter: scoreboard of per-cycle expectations checked by a negedge monitor.
module tb_queue_push_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b1111;
    logic [31:0] data = {8'h44, 8'hA5, 8'h22, 8'h11};
    logic        flush_req = 1'b0;
    logic        q_full = 1'b0;
    logic [3:0]  grant;
    logic        q_push, q_flush, busy;
    logic [7:0]  q_data;
    logic [15:0] cnt;

    logic [2:0]  req3 = 3'b000;
    logic [23:0] data3 = {8'h33, 8'h22, 8'h11};
    logic        zero3 = 1'b0;
    logic [2:0]  grant3;
    logic        push3, flush3, busy3;
    logic [7:0]  qdata3;
    logic [15:0] cnt3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  grant;
        logic [7:0]  data;
        logic        busy;
        logic        flush;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];

    logic [7:0] dtab [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};

    always #5 clk = ~clk;

    queue_push_arbiter #(.NUM_REQ(4)) dut (
        .clk(clk), .reset(reset), .req_IN(req), .data_IN(data), .grant_OUT(grant),
        .flushReq_IN(flush_req), .qFull_IN(q_full), .qPushReq_OUT(q_push),
        .qData_OUT(q_data), .qFlush_OUT(q_flush), .busy_OUT(busy), .grantCount_OUT(cnt)
    );

    queue_push_arbiter #(.NUM_REQ(3)) dut3 (
        .clk(clk), .reset(reset), .req_IN(req3), .data_IN(data3), .grant_OUT(grant3),
        .flushReq_IN(zero3), .qFull_IN(zero3), .qPushReq_OUT(push3),
        .qData_OUT(qdata3), .qFlush_OUT(flush3), .busy_OUT(busy3), .grantCount_OUT(cnt3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One directed cycle: drive inputs and queue the hand-computed outputs for that cycle.
    task automatic cyc(input logic [3:0] r, input logic f, input logic q, input logic [3:0] g,
                       input logic b, input logic fl, input int c);
        exp_t e;
        @(posedge clk);
        #1;
        req = r; flush_req = f; q_full = q;
        e.grant = g; e.busy = b; e.flush = fl; e.cnt = 16'(c); e.data = 8'h00;
        for (int i = 0; i < 4; i++) if (g[i]) e.data = dtab[i];
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1; req = 4'b0000; flush_req = 1'b0; q_full = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("grant", 32'(grant), 32'(e.grant));
            chk("push", 32'(q_push), 32'(|e.grant));
            chk("data", 32'(q_data), 32'(e.data));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("qflush", 32'(q_flush), 32'(e.flush));
            chk("count", 32'(cnt), 32'(e.cnt));
        end
    end

    initial begin
        // Reset with all requests up: every output must read 0.
        #3;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_push", 32'(q_push), 0);
        chk("rst_data", 32'(q_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(cnt), 0);
        @(posedge clk);
        #1 reset = 1'b0; req = 4'b0000;

        // Basic single grant
        cyc(4'b0100, 0, 0, 4'b0100, 0, 0, 0);
        cyc(4'b0000, 0, 0, 4'b0000, 0, 0, 1);

        // Round-robin from a fresh pointer
        do_reset();
        cyc(4'b1111, 0, 0, 4'b0001, 0, 0, 0);
        cyc(4'b1111, 0, 0, 4'b0010, 0, 0, 1);
        cyc(4'b1111, 0, 0, 4'b0100, 0, 0, 2);
        cyc(4'b1111, 0, 0, 4'b1000, 0, 0, 3);
        cyc(4'b1111, 0, 0, 4'b0001, 0, 0, 4);
        cyc(4'b1111, 0, 0, 4'b0010, 0, 0, 5);
        cyc(4'b1111, 0, 0, 4'b0100, 0, 0, 6);
        cyc(4'b1111, 0, 0, 4'b1000, 0, 0, 7);
        cyc(4'b0000, 0, 0, 4'b0000, 0, 0, 8);

        // Full blocks grants and holds the pointer (ptr=2 after producer 1)
        cyc(4'b0010, 0, 0, 4'b0010, 0, 0, 8);
        cyc(4'b0011, 0, 1, 4'b0000, 0, 0, 9);
        cyc(4'b0011, 0, 1, 4'b0000, 0, 0, 9);
        cyc(4'b0011, 0, 0, 4'b0001, 0, 0, 9);
        cyc(4'b0010, 0, 0, 4'b0010, 0, 0, 10);

        // Flush wins over requests, then two hold cycles, then restart at producer 0
        cyc(4'b1111, 1, 0, 4'b0000, 0, 0, 11);
        cyc(4'b1111, 0, 0, 4'b0000, 1, 1, 11);
        cyc(4'b1111, 0, 0, 4'b0000, 1, 0, 0);
        cyc(4'b1111, 0, 0, 4'b0000, 1, 0, 0);
        cyc(4'b1111, 0, 0, 4'b0001, 0, 0, 0);
        cyc(4'b1111, 0, 0, 4'b0010, 0, 0, 1);

        // Re-flush from HOLD
        cyc(4'b0000, 1, 0, 4'b0000, 0, 0, 2);
        cyc(4'b0000, 0, 0, 4'b0000, 1, 1, 2);
        cyc(4'b0000, 1, 0, 4'b0000, 1, 0, 0);
        cyc(4'b0000, 0, 0, 4'b0000, 1, 1, 0);
        cyc(4'b1111, 0, 0, 4'b0000, 1, 0, 0);

        // Async reset mid-HOLD
        @(posedge clk);
        #1 chk("hold_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("midrst_grant", 32'(grant), 0);
        chk("midrst_push", 32'(q_push), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_qflush", 32'(q_flush), 0);
        chk("midrst_cnt", 32'(cnt), 0);
        req = 4'b0000;
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(4'b1111, 0, 0, 4'b0001, 0, 0, 0);
        cyc(4'b1111, 0, 0, 4'b0010, 0, 0, 1);
        cyc(4'b0000, 0, 0, 4'b0000, 0, 0, 2);

        // Non-power-of-two instance: order 0,1,2,0,1
        @(posedge clk);
        #1 req3 = 3'b111;
        for (int i = 0; i < 5; i++) begin
            logic [2:0] tab [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
            logic [7:0] dt3 [5] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22};
            @(negedge clk);
            chk("n3_grant", 32'(grant3), 32'(tab[i]));
            chk("n3_data", 32'(qdata3), 32'(dt3[i]));
            chk("n3_cnt", 32'(cnt3), i);
        end
        req3 = 3'b000;

        @(posedge clk);
        @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
